// File: rtl/accel_spi_responder.sv
// SPI mode-0 slave model of the accelerometer: 0x0A write / 0x0B read with burst auto-increment.
// Optional ACCEL_SNAPSHOT_EN defers samples strobed while SS is low until SS rises.
module accel_spi_responder #(
    parameter int         NREGS    = 64,
    parameter logic [7:0] DEVID    = 8'hAD,
    parameter logic [7:0] RO_LIMIT = 8'h20
) (
    input  logic       vgaclk,
    input  logic       rst_n,
    input  logic       SPIclk,
    input  logic       SS,
    input  logic       MOSI,
    output logic       MISO,
    input  logic       sample_valid,
    input  logic [7:0] sample_x,
    input  logic [7:0] sample_y,
    input  logic [7:0] sample_z,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data
);

    localparam int AW = $clog2(NREGS);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, RDATA, WDATA, IGNORE} state_t;

    logic [2:0]    sclk_q, sclk_d;
    logic [2:0]    ss_q, ss_d;
    logic [1:0]    mosi_q, mosi_d;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    rx_q, rx_d;
    logic [7:0]    tx_q, tx_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          rd_q, rd_d;
    logic          miso_q, miso_d;
    logic          wr_valid_q, wr_valid_d;
    logic [7:0]    wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    regs_q [NREGS];
    logic [7:0]    regs_d [NREGS];
`ifdef ACCEL_SNAPSHOT_EN
    logic          pend_q, pend_d;
    logic [7:0]    pend_x_q, pend_x_d;
    logic [7:0]    pend_y_q, pend_y_d;
    logic [7:0]    pend_z_q, pend_z_d;
`endif

    logic          sclk_rise, sclk_fall, ss_rise, ss_fall, ss_low;
    logic [7:0]    rx_byte;
    logic [AW-1:0] addr_rx, addr_inc;

    // Bit [0] is the first synchronizer stage, [1] the synchronized value, [2] its previous cycle.
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign ss_rise   = ss_q[1] & ~ss_q[2];
    assign ss_fall   = ~ss_q[1] & ss_q[2];
    assign ss_low    = ~ss_q[1];
    assign rx_byte   = {rx_q[6:0], mosi_q[1]};
    assign addr_rx   = AW'(rx_byte % NREGS);
    assign addr_inc  = (addr_q == AW'(NREGS - 1)) ? '0 : addr_q + 1'b1;

    assign MISO     = miso_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

    always_comb begin
        sclk_d     = {sclk_q[1:0], SPIclk};
        ss_d       = {ss_q[1:0], SS};
        mosi_d     = {mosi_q[0], MOSI};
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        addr_d     = addr_q;
        rd_d       = rd_q;
        miso_d     = miso_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        regs_d     = regs_q;
`ifdef ACCEL_SNAPSHOT_EN
        pend_d     = pend_q;
        pend_x_d   = pend_x_q;
        pend_y_d   = pend_y_q;
        pend_z_d   = pend_z_q;
`endif

        if (ss_rise) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            if (ss_fall) begin
                state_d   = CMD;
                bit_cnt_d = '0;
            end
        end else if (state_q != IGNORE && sclk_rise) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                case (state_q)
                    CMD: begin
                        if (rx_byte == 8'h0B) begin
                            state_d = ADDR;
                            rd_d    = 1'b1;
                        end else if (rx_byte == 8'h0A) begin
                            state_d = ADDR;
                            rd_d    = 1'b0;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                    ADDR: begin
                        addr_d = addr_rx;
                        if (rd_q) begin
                            state_d = RDATA;
                            tx_d    = regs_q[addr_rx];
                        end else begin
                            state_d = WDATA;
                        end
                    end
                    RDATA: begin
                        addr_d = addr_inc;
                        tx_d   = regs_q[addr_inc];
                    end
                    WDATA: begin
                        if (8'(addr_q) >= RO_LIMIT) begin
                            regs_d[addr_q] = rx_byte;
                            wr_valid_d     = 1'b1;
                            wr_addr_d      = 8'(addr_q);
                            wr_data_d      = rx_byte;
                        end
                        addr_d = addr_inc;
                    end
                    default: ;
                endcase
            end
        end

        // MISO only carries data in RDATA; rises and falls never coincide, so tx_d has one writer per cycle.
        if (state_q != RDATA || ss_rise) begin
            miso_d = 1'b0;
        end else if (sclk_fall) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
        end

        // Samples are applied after the SPI write so they win on a shared register.
`ifdef ACCEL_SNAPSHOT_EN
        if (ss_rise && pend_q) begin
            regs_d[8]  = pend_x_q;
            regs_d[9]  = pend_y_q;
            regs_d[10] = pend_z_q;
            pend_d     = 1'b0;
        end
        if (sample_valid) begin
            if (ss_low) begin
                pend_d   = 1'b1;
                pend_x_d = sample_x;
                pend_y_d = sample_y;
                pend_z_d = sample_z;
            end else begin
                regs_d[8]  = sample_x;
                regs_d[9]  = sample_y;
                regs_d[10] = sample_z;
            end
        end
`else
        if (sample_valid) begin
            regs_d[8]  = sample_x;
            regs_d[9]  = sample_y;
            regs_d[10] = sample_z;
        end
`endif
    end

    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q     <= '0;
            ss_q       <= '1;
            mosi_q     <= '0;
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            miso_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= (i == 0) ? DEVID : 8'h00;
`ifdef ACCEL_SNAPSHOT_EN
            pend_q     <= 1'b0;
            pend_x_q   <= '0;
            pend_y_q   <= '0;
            pend_z_q   <= '0;
`endif
        end else begin
            sclk_q     <= sclk_d;
            ss_q       <= ss_d;
            mosi_q     <= mosi_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            miso_q     <= miso_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            regs_q     <= regs_d;
`ifdef ACCEL_SNAPSHOT_EN
            pend_q     <= pend_d;
            pend_x_q   <= pend_x_d;
            pend_y_q   <= pend_y_d;
            pend_z_q   <= pend_z_d;
`endif
        end
    end

endmodule

// File: tb/tb_accel_spi_responder.sv
// Bench for accel_spi_responder: table of SPI transactions with read/write scoreboards,
// plus hand sequences for an aborted write and a reset in the middle of a read.
module tb_accel_spi_responder;

    localparam int HALF = 16;

    logic       vgaclk = 1'b0;
    logic       rst_n, SPIclk, SS, MOSI, MISO;
    logic       sample_valid;
    logic [7:0] sample_x, sample_y, sample_z;
    logic       wr_valid;
    logic [7:0] wr_addr, wr_data;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0]  rd_q [$];
    logic [15:0] wr_q [$];

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  addr;
        int          n;
        logic [31:0] dat;    // byte i at [8*i +: 8]
        logic [31:0] exp;
        logic [3:0]  wmask;  // bit i: byte i must produce a wr_valid pulse
        bit          rd;
        bit          pre;    // strobe 11/22/33 before the transfer
        bit          mid;    // strobe 44/55/66 during the first data byte
    } vec_t;

    vec_t vecs [17];

    accel_spi_responder dut (
        .vgaclk(vgaclk), .rst_n(rst_n), .SPIclk(SPIclk), .SS(SS), .MOSI(MOSI), .MISO(MISO),
        .sample_valid(sample_valid), .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 vgaclk = ~vgaclk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t v(input logic [7:0] cmd, input logic [7:0] addr, input int n,
                               input logic [31:0] dat, input logic [31:0] exp, input logic [3:0] wm,
                               input bit rd, input bit pre, input bit mid);
        vec_t t;
        t.cmd = cmd; t.addr = addr; t.n = n; t.dat = dat; t.exp = exp;
        t.wmask = wm; t.rd = rd; t.pre = pre; t.mid = mid;
        return t;
    endfunction

    // Every write pulse must match the oldest expected write.
    always @(negedge vgaclk) begin
        if (rst_n === 1'b1 && wr_valid === 1'b1) begin
            if (wr_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_wr: got addr %h data %h expected no write", wr_addr, wr_data);
            end else begin
                chk("wr_addr_data", {wr_addr, wr_data}, wr_q.pop_front());
            end
        end
    end

    task automatic strobe(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
        @(negedge vgaclk);
        sample_x = x; sample_y = y; sample_z = z; sample_valid = 1'b1;
        @(negedge vgaclk);
        sample_valid = 1'b0;
        repeat (2) @(negedge vgaclk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nb, input bit mid, output logic [7:0] rx);
        rx = '0;
        for (int b = 7; b > 7 - nb; b--) begin
            MOSI = tx[b];
            repeat (HALF) @(negedge vgaclk);
            SPIclk = 1'b1;
            rx = {rx[6:0], MISO};
            if (mid && b == 4) begin
                sample_x = 8'h44; sample_y = 8'h55; sample_z = 8'h66; sample_valid = 1'b1;
                @(negedge vgaclk);
                sample_valid = 1'b0;
                repeat (HALF - 1) @(negedge vgaclk);
            end else begin
                repeat (HALF) @(negedge vgaclk);
            end
            SPIclk = 1'b0;
        end
    endtask

    task automatic ss_begin();
        SS = 1'b0;
        repeat (HALF) @(negedge vgaclk);
    endtask

    task automatic ss_end();
        repeat (HALF) @(negedge vgaclk);
        SS = 1'b1;
        repeat (2 * HALF) @(negedge vgaclk);
    endtask

    task automatic run_txn(input vec_t t);
        logic [7:0] rx;
        if (t.pre) strobe(8'h11, 8'h22, 8'h33);
        ss_begin();
        spi_bits(t.cmd, 8, 1'b0, rx);
        chk("miso_in_cmd", 16'(rx), 16'h0000);
        spi_bits(t.addr, 8, 1'b0, rx);
        chk("miso_in_addr", 16'(rx), 16'h0000);
        for (int i = 0; i < t.n; i++) begin
            if (t.rd) rd_q.push_back(t.exp[8*i +: 8]);
            if (t.wmask[i]) wr_q.push_back({8'((32'(t.addr) + i) % 64), t.dat[8*i +: 8]});
            spi_bits(t.dat[8*i +: 8], 8, t.mid && i == 0, rx);
            if (t.rd) chk("rd_data", 16'(rx), 16'(rd_q.pop_front()));
        end
        ss_end();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish within 90000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx;

        //               cmd    addr   n  dat           exp           wm    rd pre mid
        vecs[0]  = v(8'h0B, 8'h00, 1, 32'h0,       32'h000000AD, 4'b0000, 1, 0, 0);
        vecs[1]  = v(8'h0A, 8'h2D, 1, 32'h02,      32'h0,        4'b0001, 0, 0, 0);
        vecs[2]  = v(8'h0B, 8'h2D, 1, 32'h0,       32'h00000002, 4'b0000, 1, 0, 0);
        vecs[3]  = v(8'h0B, 8'h08, 3, 32'h0,       32'h00332211, 4'b0000, 1, 1, 0);
        vecs[4]  = v(8'h0B, 8'h3F, 2, 32'h0,       32'h0000AD00, 4'b0000, 1, 0, 0);
        vecs[5]  = v(8'h0A, 8'h08, 1, 32'h77,      32'h0,        4'b0000, 0, 0, 0);
        vecs[6]  = v(8'h0B, 8'h08, 1, 32'h0,       32'h00000011, 4'b0000, 1, 0, 0);
        vecs[7]  = v(8'h55, 8'h00, 2, 32'hFFFF,    32'h00000000, 4'b0000, 1, 0, 0);
        vecs[8]  = v(8'h0A, 8'h3E, 3, 32'hA3A2A1,  32'h0,        4'b0011, 0, 0, 0);
        vecs[9]  = v(8'h0A, 8'h1F, 2, 32'hB2B1,    32'h0,        4'b0010, 0, 0, 0);
        vecs[10] = v(8'h0B, 8'h3E, 4, 32'h0,       32'h00ADA2A1, 4'b0000, 1, 0, 0);
        vecs[11] = v(8'h0B, 8'h1F, 2, 32'h0,       32'h0000B200, 4'b0000, 1, 0, 0);
        vecs[12] = v(8'h0B, 8'h6D, 1, 32'h0,       32'h00000002, 4'b0000, 1, 0, 0);
        vecs[13] = v(8'h0A, 8'h7F, 1, 32'hC3,      32'h0,        4'b0001, 0, 0, 0);
        vecs[14] = v(8'h0B, 8'h3F, 1, 32'h0,       32'h000000C3, 4'b0000, 1, 0, 0);
`ifdef ACCEL_SNAPSHOT_EN
        vecs[15] = v(8'h0B, 8'h08, 3, 32'h0,       32'h00332211, 4'b0000, 1, 1, 1);
`else
        vecs[15] = v(8'h0B, 8'h08, 3, 32'h0,       32'h00665511, 4'b0000, 1, 1, 1);
`endif
        vecs[16] = v(8'h0B, 8'h08, 3, 32'h0,       32'h00665544, 4'b0000, 1, 0, 0);

        rst_n = 1'b0; SPIclk = 1'b0; SS = 1'b1; MOSI = 1'b0;
        sample_valid = 1'b0; sample_x = '0; sample_y = '0; sample_z = '0;
        repeat (4) @(negedge vgaclk);
        chk("rst_miso", 16'(MISO), 16'h0);
        chk("rst_wr_valid", 16'(wr_valid), 16'h0);
        chk("rst_wr_addr", 16'(wr_addr), 16'h0);
        chk("rst_wr_data", 16'(wr_data), 16'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge vgaclk);

        for (int i = 0; i < 15; i++) run_txn(vecs[i]);

        // Write aborted after 4 data bits must not land.
        ss_begin();
        spi_bits(8'h0A, 8, 1'b0, rx);
        spi_bits(8'h30, 8, 1'b0, rx);
        spi_bits(8'hFF, 4, 1'b0, rx);
        ss_end();
        run_txn(v(8'h0B, 8'h30, 1, 32'h0, 32'h0, 4'b0000, 1, 0, 0));

        // Reset while reg 0x00 (MSB 1) is on MISO.
        ss_begin();
        spi_bits(8'h0B, 8, 1'b0, rx);
        spi_bits(8'h00, 8, 1'b0, rx);
        repeat (6) @(negedge vgaclk);
        chk("miso_before_rst", 16'(MISO), 16'h1);
        rst_n = 1'b0;
        #1;
        chk("miso_in_rst", 16'(MISO), 16'h0);
        chk("wr_valid_in_rst", 16'(wr_valid), 16'h0);
        repeat (4) @(negedge vgaclk);
        SS = 1'b1;
        repeat (4) @(negedge vgaclk);
        rst_n = 1'b1;
        repeat (4) @(negedge vgaclk);
        run_txn(v(8'h0B, 8'h00, 1, 32'h0, 32'h000000AD, 4'b0000, 1, 0, 0));
        run_txn(v(8'h0B, 8'h2D, 1, 32'h0, 32'h00000000, 4'b0000, 1, 0, 0));

        run_txn(vecs[15]);
        run_txn(vecs[16]);

        chk("wr_queue_drained", 16'(wr_q.size()), 16'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
